// File: rtl/control_fsm_if.sv
// Control bundle between the multi-cycle datapath and its control FSM.
//
// Memory handshake: while the controller holds MemRead or MemWrite high it
// is presenting a request; the memory completes that request in the cycle it
// drives mem_ready=1. The request stays asserted, unchanged, until that
// cycle. mem_ready outside a request is meaningless and is ignored.
//
// opcode/funct come from the instruction register, which is loaded on the
// clock edge that ends the FETCH cycle where IRWrite=1. They therefore hold
// the current instruction from DECODE until the next fetch completes.
interface control_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       Zero;
    logic       mem_ready;

    logic [2:0] ALUOp;
    logic       ALUSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic [1:0] PCSrc;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemToReg;
    logic [2:0] state;
    logic       illegal;

    // Datapath side: supplies instruction fields and status, consumes controls.
    modport master (
        output opcode, funct, Zero, mem_ready,
        input  ALUOp, ALUSrc, IRWrite, PCWrite, PCSrc, MemRead, MemWrite,
        input  RegWrite, RegDst, MemToReg, state, illegal
    );

    // Controller side.
    modport slave (
        input  opcode, funct, Zero, mem_ready,
        output ALUOp, ALUSrc, IRWrite, PCWrite, PCSrc, MemRead, MemWrite,
        output RegWrite, RegDst, MemToReg, state, illegal
    );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle MIPS-subset control unit.
//
// Sequence: FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH.
// The only storage is the state register and the sticky illegal flag; every
// control output is decoded combinationally from the current state and the
// instruction fields. All enables are forced low while rst_n is low so that a
// reset in the middle of a memory write drops the write in the same cycle.
module control_fsm #(
    parameter bit ILLEGAL_HALT = 1'b1  // 1: undecoded instruction halts, 0: acts as a NOP
) (
    input  logic         clk,
    input  logic         rst_n,
    control_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'b000,
        ST_DECODE = 3'b001,
        ST_EXEC   = 3'b010,
        ST_MEM    = 3'b011,
        ST_WB     = 3'b100,
        ST_HALT   = 3'b111
    } state_t;

    // Instruction classes; each class follows one path through the FSM.
    typedef enum logic [2:0] {
        CLS_BAD,
        CLS_R,
        CLS_IALU,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_J
    } class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    state_t     state_q;
    state_t     state_d;
    logic       illegal_q;

    class_t     cls;
    logic [2:0] alu_op_dec;

    logic [2:0] alu_op;
    logic       alu_src;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;

    // Classify the instruction in the IR and pick the ALU operation it needs.
    always_comb begin
        cls        = CLS_BAD;
        alu_op_dec = ALU_ADD;
        case (bus.opcode)
            OP_RTYPE: begin
                case (bus.funct)
                    FN_ADD: begin cls = CLS_R; alu_op_dec = ALU_ADD; end
                    FN_SUB: begin cls = CLS_R; alu_op_dec = ALU_SUB; end
                    FN_XOR: begin cls = CLS_R; alu_op_dec = ALU_XOR; end
                    FN_OR:  begin cls = CLS_R; alu_op_dec = ALU_OR;  end
                    FN_AND: begin cls = CLS_R; alu_op_dec = ALU_AND; end
                    FN_SLT: begin cls = CLS_R; alu_op_dec = ALU_SLT; end
                    default: ;
                endcase
            end
            OP_ADDI: begin cls = CLS_IALU; alu_op_dec = ALU_ADD; end
            OP_XORI: begin cls = CLS_IALU; alu_op_dec = ALU_XOR; end
            OP_ORI:  begin cls = CLS_IALU; alu_op_dec = ALU_OR;  end
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_BEQ:  begin cls = CLS_BEQ; alu_op_dec = ALU_SUB; end
            OP_J:    cls = CLS_J;
            default: ;
        endcase
    end

    // Next-state and control decode; every control starts from its idle value.
    always_comb begin
        state_d    = state_q;
        alu_op     = ALU_ADD;
        alu_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SEQ;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // PC+4 is computed by the ALU in parallel with the read.
                mem_read = 1'b1;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_SEQ;
                    state_d  = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (cls == CLS_BAD) begin
                    state_d = ILLEGAL_HALT ? ST_HALT : ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                case (cls)
                    CLS_R: begin
                        alu_op  = alu_op_dec;
                        state_d = ST_WB;
                    end
                    CLS_IALU: begin
                        alu_src = 1'b1;
                        alu_op  = alu_op_dec;
                        state_d = ST_WB;
                    end
                    CLS_LW, CLS_SW: begin
                        // Effective address = base + offset.
                        alu_src = 1'b1;
                        state_d = ST_MEM;
                    end
                    CLS_BEQ: begin
                        // Compare by subtraction; branch only when equal.
                        alu_op   = ALU_SUB;
                        pc_src   = PC_BRANCH;
                        pc_write = bus.Zero;
                        state_d  = ST_FETCH;
                    end
                    CLS_J: begin
                        pc_src   = PC_JUMP;
                        pc_write = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end

            ST_MEM: begin
                // Keep the address path steady for the whole access.
                alu_src = 1'b1;
                if (cls == CLS_LW) begin
                    mem_read = 1'b1;
                    if (bus.mem_ready) state_d = ST_WB;
                end else if (cls == CLS_SW) begin
                    mem_write = 1'b1;
                    if (bus.mem_ready) state_d = ST_FETCH;
                end else begin
                    state_d = ST_FETCH;
                end
            end

            ST_WB: begin
                reg_write = 1'b1;
                state_d   = ST_FETCH;
                case (cls)
                    CLS_R:   reg_dst    = 1'b1;
                    CLS_LW:  mem_to_reg = 1'b1;
                    default: ;
                endcase
            end

            ST_HALT: state_d = ST_HALT;

            default: state_d = ST_FETCH;
        endcase
    end

    // State register; reset restarts at FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Sticky record that an undecodable instruction reached DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (state_q == ST_DECODE && cls == CLS_BAD) begin
            illegal_q <= 1'b1;
        end
    end

    // Enables are qualified by rst_n so reset silences them without a clock.
    assign bus.IRWrite  = ir_write  & rst_n;
    assign bus.PCWrite  = pc_write  & rst_n;
    assign bus.MemRead  = mem_read  & rst_n;
    assign bus.MemWrite = mem_write & rst_n;
    assign bus.RegWrite = reg_write & rst_n;

    assign bus.ALUOp    = alu_op;
    assign bus.ALUSrc   = alu_src;
    assign bus.PCSrc    = pc_src;
    assign bus.RegDst   = reg_dst;
    assign bus.MemToReg = mem_to_reg;
    assign bus.state    = state_q;
    assign bus.illegal  = illegal_q;

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 The block SHALL have this parameter: ILLEGAL_HALT, default 1, 1 = unknown opcode/funct enters HALT, 0 = treated as NOP.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
  clk  input  1  single clock, rising edge
  rst_n  input  1  asynchronous, active-low reset
  opcode  input  6  instruction[31:26] from the instruction register
  funct  input  6  instruction[5:0]
  Zero  input  1  ALU zero flag
  mem_ready  input  1  memory completes the current access this cycle
  ALUOp  output  3  000 add, 001 sub, 010 xor, 011 or, 100 and, 101 slt
  ALUSrc  output  1  1 = ALU B operand is the extended immediate
  IRWrite  output  1  load the instruction register
  PCWrite  output  1  load the PC
  PCSrc  output  2  00 PC+4, 01 branch target, 10 jump target
  MemRead  output  1  memory read request
  MemWrite  output  1  memory write request
  RegWrite  output  1  register file write enable
  RegDst  output  1  1 = destination is rd, 0 = rt
  MemToReg  output  1  1 = write-back data comes from memory
  state  output  3  current state, for debug
  illegal  output  1  sticky flag for an undecoded instruction
REQ-003 Reset SHALL be asynchronous and active-low; clk SHALL be the only clock.

Function
REQ-004 The state register SHALL be the only state-holding element besides illegal; all other outputs SHALL be combinational from state, opcode, funct, Zero and mem_ready.
REQ-005 State encoding SHALL be FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, HALT=111.
REQ-006 FETCH SHALL:
  - assert MemRead=1 and ALUOp=000;
  - assert IRWrite=1, PCWrite=1 and PCSrc=00 only in the cycle where mem_ready=1, then move to DECODE;
  - otherwise hold in FETCH.
REQ-007 DECODE SHALL last exactly one cycle, assert no enables, then go to EXEC for a legal instruction, or to HALT (ILLEGAL_HALT=1) or FETCH (ILLEGAL_HALT=0) for an illegal one.
REQ-008 Legal R-type instructions SHALL be opcode=000000 with funct 100000 add, 100010 sub, 100110 xor, 100101 or, 100100 and, 101010 slt, which map to ALUOp 000/001/010/011/100/101.
REQ-009 Legal I-type instructions SHALL be addi 001000, xori 001110, ori 001101, lw 100011, sw 101011, beq 000100, and the jump instruction SHALL be j 000010.
REQ-010 In EXEC:
  - R-type: ALUSrc=0 and the funct-mapped ALUOp, then go to WB.
  - addi, xori, ori: ALUSrc=1 with ALUOp 000/010/011, then go to WB.
  - lw, sw: ALUSrc=1, ALUOp=000, then go to MEM.
REQ-011 In EXEC for beq: ALUSrc=0, ALUOp=001, PCSrc=01, PCWrite=Zero, then go to FETCH.
REQ-012 In EXEC for j: PCSrc=10, PCWrite=1, then go to FETCH.
REQ-013 MEM SHALL assert MemRead (lw) or MemWrite (sw) and hold ALUOp=000, ALUSrc=1 until mem_ready=1; then lw goes to WB and sw goes to FETCH.
REQ-014 WB SHALL assert RegWrite=1 for exactly one cycle, then go to FETCH, with:
  - R-type: RegDst=1, MemToReg=0;
  - I-type ALU: RegDst=0, MemToReg=0;
  - lw: RegDst=0, MemToReg=1.
REQ-015 With zero-wait memory, latency SHALL be R-type/I-ALU 4 cycles, lw 5, sw 4, beq 3, j 3; each FETCH or MEM stall cycle SHALL add exactly one cycle.
REQ-016 Every enable not explicitly asserted in a state SHALL be 0; ALUOp SHALL default to 000, and ALUSrc, PCSrc, RegDst and MemToReg SHALL default to 0.
REQ-017 HALT SHALL assert no enables and SHALL be exited only by reset.
REQ-018 illegal SHALL set on the DECODE cycle of an illegal instruction, regardless of ILLEGAL_HALT, and SHALL stay set until reset.
REQ-019 mem_ready SHALL be ignored in DECODE, EXEC, WB and HALT.
REQ-020 MemRead and MemWrite SHALL never be asserted in the same cycle.

Reset
REQ-021 When rst_n=0, state SHALL be FETCH and illegal SHALL be 0 immediately, without waiting for a clock edge.
REQ-022 While rst_n=0, all enables (IRWrite, PCWrite, MemRead, MemWrite, RegWrite) SHALL be 0 regardless of state.
REQ-023 A reset asserted mid-instruction, including during a MEM stall, SHALL abandon the instruction and deassert MemWrite in the same cycle.
REQ-024 The first FETCH SHALL begin on the first rising clk edge after rst_n goes high.

Verification
REQ-025 add (opcode 000000, funct 100000), mem_ready=1 -> states FETCH, DECODE, EXEC, WB; ALUOp=000 in EXEC; RegWrite=1 and RegDst=1 in WB; 4 cycles total.
REQ-026 lw (100011) with mem_ready low for 2 MEM cycles -> MemRead held for 3 MEM cycles, then WB with MemToReg=1 and RegWrite=1; 7 cycles total.
REQ-027 beq (000100) run twice, with Zero=1 then Zero=0 -> PCWrite=1, PCSrc=01 in EXEC for the first; PCWrite=0 for the second; both return to FETCH after 3 cycles.
REQ-028 opcode 111111, ILLEGAL_HALT=1 -> illegal=1 after DECODE, state=111 and all enables 0 indefinitely; with ILLEGAL_HALT=0 -> illegal=1 and state returns to FETCH.
REQ-029 sw (101011) with mem_ready=0, then rst_n pulsed low mid-MEM -> MemWrite=0 immediately; state=000; after release, FETCH with MemRead=1.
